ram_port_ctl: RTL

Initiator for one byte-enabled port of the shared dual-port block RAM: accepts byte/half/word load and store requests from the core's memory stage over a valid/ready handshake. It converts each request into the RAM's word address, lane write-enable and replicated write data, and captures the read word after the RAM's one-cycle latency. It returns lane-extracted, sign- or zero-extended load data. Misaligned and illegal-size requests are rejected without touching the RAM.

---
 rtl/ram_port_pkg.sv | 61 ++++++
 rtl/ram_load_extract.sv | 34 +++
 rtl/ram_port_ctl.sv | 117 +++++++++++
 3 files changed

// File: rtl/ram_port_pkg.sv
// Shared definitions for the block-RAM port initiators: access sizes,
// controller state encoding, lane write-enable masks and request helpers.
package ram_port_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDATA  = 2'd2
  } state_t;

  localparam logic [3:0] LANE_NONE = 4'b0000;
  localparam logic [3:0] LANE_B0   = 4'b0001;
  localparam logic [3:0] LANE_B1   = 4'b0010;
  localparam logic [3:0] LANE_B2   = 4'b0100;
  localparam logic [3:0] LANE_B3   = 4'b1000;
  localparam logic [3:0] LANE_LO   = 4'b0011;
  localparam logic [3:0] LANE_HI   = 4'b1100;
  localparam logic [3:0] LANE_ALL  = 4'b1111;

  // Illegal size is folded in here so the accept path has one reject test.
  function automatic logic req_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[0];
      SIZE_WORD: return (off != 2'b00);
      default:   return 1'b1;
    endcase
  endfunction

  // Only legal masks can come out of here; anything else maps to no write.
  function automatic logic [3:0] store_lanes(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: begin
        case (off)
          2'd0:    return LANE_B0;
          2'd1:    return LANE_B1;
          2'd2:    return LANE_B2;
          default: return LANE_B3;
        endcase
      end
      SIZE_HALF: return off[1] ? LANE_HI : LANE_LO;
      SIZE_WORD: return LANE_ALL;
      default:   return LANE_NONE;
    endcase
  endfunction

  // Replicating the right-justified data lets the lane enables pick the slot.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SIZE_BYTE: return {4{wdata[7:0]}};
      SIZE_HALF: return {2{wdata[15:0]}};
      default:   return wdata;
    endcase
  endfunction

endpackage

// File: rtl/ram_load_extract.sv
// Combinational load formatter: picks the addressed byte/half out of a RAM
// word and sign- or zero-extends it. Word loads pass through untouched.
module ram_load_extract
  import ram_port_pkg::*;
(
  input  logic [31:0] dout,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane selection followed by extension.
  always_comb begin
    lane_b = 8'h00;
    lane_h = off[1] ? dout[31:16] : dout[15:0];
    result = dout;
    case (off)
      2'd0:    lane_b = dout[7:0];
      2'd1:    lane_b = dout[15:8];
      2'd2:    lane_b = dout[23:16];
      default: lane_b = dout[31:24];
    endcase
    case (size)
      SIZE_BYTE: result = zero_ext ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};
      SIZE_HALF: result = zero_ext ? {16'h0000, lane_h}   : {{16{lane_h[15]}}, lane_h};
      default:   result = dout;
    endcase
  end

endmodule

// File: rtl/ram_port_ctl.sv
// Byte-enabled load/store initiator for one port of the shared block RAM.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | ready for a request; rejects bad ones with a 1-cycle error
//   ST_ACCESS | ram_en high for one cycle; RAM writes or samples address
//   ST_RDATA  | RAM read word present on ram_dout; format and respond
module ram_port_ctl
  import ram_port_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [31:0]           rsp_rdata,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout
);

  state_t      state;
  logic [1:0]  lat_off;
  logic [1:0]  lat_size;
  logic        lat_zext;
  logic        lat_write;
  logic [31:0] load_word;

  ram_load_extract u_extract (
    .dout     (ram_dout),
    .off      (lat_off),
    .size     (lat_size),
    .zero_ext (lat_zext),
    .result   (load_word)
  );

  // Controller FSM; every output is registered so the RAM sees clean strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0000_0000;
      ram_en    <= 1'b0;
      ram_we    <= LANE_NONE;
      ram_addr  <= '0;
      ram_din   <= 32'h0000_0000;
      lat_off   <= 2'b00;
      lat_size  <= SIZE_BYTE;
      lat_zext  <= 1'b0;
      lat_write <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            if (req_misaligned(req_size, req_addr[1:0])) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state     <= ST_ACCESS;
              req_ready <= 1'b0;
              ram_en    <= 1'b1;
              ram_addr  <= req_addr[ADDR_WIDTH+1:2];
              lat_off   <= req_addr[1:0];
              lat_size  <= req_size;
              lat_zext  <= req_unsigned;
              lat_write <= req_write;
              if (req_write) begin
                ram_we  <= store_lanes(req_size, req_addr[1:0]);
                ram_din <= store_data(req_size, req_wdata);
              end else begin
                ram_we  <= LANE_NONE;
              end
            end
          end
        end
        ST_ACCESS: begin
          ram_en <= 1'b0;
          ram_we <= LANE_NONE;
          if (lat_write) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b1;
          end else begin
            state <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b1;
          rsp_rdata <= load_word;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          ram_en    <= 1'b0;
          ram_we    <= LANE_NONE;
        end
      endcase
    end
  end

endmodule
